// File: rtl/conv_lane_mac_if.sv
// Stream bundle for one conv MAC lane: packed input samples in, window sums out.
// The lane uses the slave modport and the upstream/downstream side uses master.
interface conv_lane_mac_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 2*WIDTH + 4
);
    logic                        s_valid;
    logic                        s_ready;
    logic        [2*WIDTH-1:0]   s_data;
    logic                        s_last;
    logic                        m_valid;
    logic                        m_ready;
    logic signed [ACC_WIDTH-1:0] m_data;
    logic                        m_last;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/conv_lane_mac.sv
// One multiplier lane: loads a KERNEL_SIZE weight set per packet, then emits the
// signed dot product of each activation window on a registered valid/ready port.
module conv_lane_mac #(
    parameter int WIDTH       = 16,
    parameter int KERNEL_SIZE = 9,
    parameter int LANE        = 0,
    parameter int ACC_WIDTH   = 2*WIDTH + $clog2(KERNEL_SIZE)
) (
    input  logic          clk,
    input  logic          rstn,
    conv_lane_mac_if.slave bus
);

    localparam int IDX_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(KERNEL_SIZE - 1);

    typedef enum logic {
        LOAD_W = 1'b0,
        MAC    = 1'b1
    } state_t;

    state_t                      state_q,   state_d;
    logic        [IDX_W-1:0]     idx_q,     idx_d;
    logic signed [ACC_WIDTH-1:0] acc_q,     acc_d;
    logic signed [WIDTH-1:0]     weight_q [KERNEL_SIZE];
    logic signed [WIDTH-1:0]     weight_d [KERNEL_SIZE];
    logic                        m_valid_q, m_valid_d;
    logic signed [ACC_WIDTH-1:0] m_data_q,  m_data_d;
    logic                        m_last_q,  m_last_d;

    logic                        s_ready_c;
    logic                        accept;
    logic                        win_close;
    logic signed [WIDTH-1:0]     x;
    logic signed [2*WIDTH-1:0]   prod;
    logic signed [ACC_WIDTH-1:0] sum;

    assign x = (LANE != 0) ? $signed(bus.s_data[2*WIDTH-1:WIDTH])
                           : $signed(bus.s_data[WIDTH-1:0]);

    // Input stage: multiply against the weight at the current window position
    assign prod = x * weight_q[idx_q];
    assign sum  = acc_q + ACC_WIDTH'(prod);

    // The single output register may be refilled in the cycle it drains, hence m_ready here
    assign s_ready_c = (state_q == LOAD_W) ? 1'b1 : (!m_valid_q || bus.m_ready);
    assign accept    = bus.s_valid && s_ready_c;
    assign win_close = (idx_q == IDX_MAX) || bus.s_last;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        weight_d  = weight_q;
        m_valid_d = m_valid_q && !bus.m_ready;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;

        if (accept) begin
            if (state_q == LOAD_W) begin
                weight_d[idx_q] = x;
                // A packet ending inside the weight phase has no activations; start over
                if (bus.s_last) begin
                    idx_d = '0;
                end else if (idx_q == IDX_MAX) begin
                    idx_d   = '0;
                    state_d = MAC;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else if (win_close) begin
                m_data_d  = sum;
                m_last_d  = bus.s_last;
                m_valid_d = 1'b1;
                acc_d     = '0;
                idx_d     = '0;
                if (bus.s_last) begin
                    state_d = LOAD_W;
                end
            end else begin
                acc_d = sum;
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Output stage: registered result
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= LOAD_W;
            idx_q     <= '0;
            acc_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    // Kernel storage is always reloaded before use, so it carries no reset
    always_ff @(posedge clk) begin
        weight_q <= weight_d;
    end

    assign bus.s_ready = s_ready_c;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_last  = m_last_q;

endmodule

// File: tb/tb_conv_lane_mac.sv
// Bench for conv_lane_mac: two lanes (LANE=0 and LANE=1, 3-tap kernel) driven with
// directed and random packets, results checked by a queue-based scoreboard.
module tb_conv_lane_mac;

    localparam int K  = 3;
    localparam int W  = 16;
    localparam int AW = 2*W + $clog2(K);

    typedef struct {
        logic signed [63:0] d;
        logic               l;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 1;

    exp_t q0[$];
    exp_t q1[$];

    bit                 held   [2];
    logic signed [AW-1:0] held_d [2];
    logic               held_l [2];

    conv_lane_mac_if #(.WIDTH(W), .ACC_WIDTH(AW)) if0 ();
    conv_lane_mac_if #(.WIDTH(W), .ACC_WIDTH(AW)) if1 ();

    conv_lane_mac #(.WIDTH(W), .KERNEL_SIZE(K), .LANE(0)) dut0 (
        .clk (clk),
        .rstn(rstn),
        .bus (if0.slave)
    );

    conv_lane_mac #(.WIDTH(W), .KERNEL_SIZE(K), .LANE(1)) dut1 (
        .clk (clk),
        .rstn(rstn),
        .bus (if1.slave)
    );

    always #5 clk = ~clk;

    // Lane 0 backpressure: 0 = stall, 1 = always ready, 2 = random
    always @(posedge clk) begin
        #2;
        if (rdy_mode == 0)      if0.m_ready = 1'b0;
        else if (rdy_mode == 1) if0.m_ready = 1'b1;
        else                    if0.m_ready = ($urandom_range(0, 3) != 0);
    end

    initial if1.m_ready = 1'b1;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic mon(input int sel, input logic v, input logic r,
                       input logic signed [AW-1:0] d, input logic l);
        exp_t e;
        bit   have;
        if (!rstn) begin
            held[sel] = 1'b0;
            return;
        end
        if (held[sel]) begin
            chk($sformatf("lane%0d_hold_valid", sel), v, 1);
            chk($sformatf("lane%0d_hold_data", sel), d, held_d[sel]);
            chk($sformatf("lane%0d_hold_last", sel), l, held_l[sel]);
        end
        if (v && r) begin
            have = 1'b0;
            if (sel == 0 && q0.size() > 0) begin
                e = q0.pop_front(); have = 1'b1;
            end else if (sel == 1 && q1.size() > 0) begin
                e = q1.pop_front(); have = 1'b1;
            end
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL lane%0d_unexpected_result: got %0d, expected no output", sel, d);
            end else begin
                chk($sformatf("lane%0d_result_data", sel), d, e.d);
                chk($sformatf("lane%0d_result_last", sel), l, e.l);
            end
        end
        held[sel]   = v && !r;
        held_d[sel] = d;
        held_l[sel] = l;
    endtask

    always @(negedge clk) begin
        mon(0, if0.m_valid, if0.m_ready, if0.m_data, if0.m_last);
        mon(1, if1.m_valid, if1.m_ready, if1.m_data, if1.m_last);
    end

    // Called at posedge+1; returns at posedge+1 after the beat is accepted
    task automatic drive_beat(input int sel, input logic [2*W-1:0] word, input bit last);
        int n = 0;
        bit got = 1'b0;
        if (sel == 0) begin if0.s_valid = 1'b1; if0.s_data = word; if0.s_last = last; end
        else          begin if1.s_valid = 1'b1; if1.s_data = word; if1.s_last = last; end
        while (!got && n < 200) begin
            @(negedge clk);
            got = (sel == 0) ? if0.s_ready : if1.s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (sel == 0) begin if0.s_valid = 1'b0; if0.s_last = 1'b0; end
        else          begin if1.s_valid = 1'b0; if1.s_last = 1'b0; end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL lane%0d_accept_timeout: s_ready stayed 0, expected 1", sel);
        end
    endtask

    function automatic logic [2*W-1:0] pack(input int sel, input int v, input int junk);
        logic [W-1:0] h;
        logic [W-1:0] j;
        h = W'(v);
        j = (junk < 0) ? W'($urandom) : W'(junk);
        return (sel == 0) ? {j, h} : {h, j};
    endfunction

    // Reference: first K values are the kernel, the rest split into K-long windows,
    // a trailing short window is flushed at packet end
    task automatic send_pkt(input int sel, input int vals[$], input bit gaps, input int junk);
        int   n;
        int   start;
        exp_t e;
        n = vals.size();
        if (n > K) begin
            start = K;
            while (start < n) begin
                e.d = 0;
                for (int j = 0; j < K && start + j < n; j++)
                    e.d = e.d + longint'(vals[start + j]) * longint'(vals[j]);
                e.l = (start + K >= n);
                if (sel == 0) q0.push_back(e); else q1.push_back(e);
                start += K;
            end
        end
        for (int i = 0; i < n; i++) begin
            drive_beat(sel, pack(sel, vals[i], junk), i == n - 1);
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while ((q0.size() > 0 || q1.size() > 0) && n < 300);
        chk("drain_pending", q0.size() + q1.size(), 0);
    endtask

    initial begin
        int p[$];
        int n;
        int len;
        logic [W-1:0] r16;

        if0.s_valid = 1'b0; if0.s_data = '0; if0.s_last = 1'b0;
        if1.s_valid = 1'b0; if1.s_data = '0; if1.s_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid0", if0.m_valid, 0);
        chk("rst_m_data0",  if0.m_data,  0);
        chk("rst_m_last0",  if0.m_last,  0);
        chk("rst_s_ready0", if0.s_ready, 1);
        chk("rst_m_valid1", if1.m_valid, 0);
        chk("rst_s_ready1", if1.s_ready, 1);
        rstn = 1'b1;
        @(posedge clk); #1;

        p = '{1, 2, 3, 4, 5, 6};
        send_pkt(0, p, 0, -1);
        chk("latency_valid", if0.m_valid, 1);
        chk("latency_data",  if0.m_data,  32);

        p = '{1, 1, 1, 1, 2, 3, 4, 5, 6};
        send_pkt(0, p, 0, -1);
        p = '{2, 2, 2, 5, 7};
        send_pkt(0, p, 0, -1);
        p = '{9, 9};
        send_pkt(0, p, 0, -1);
        p = '{1, 1, 1, 3, 3, 3};
        send_pkt(0, p, 0, -1);
        drain();

        // Stall the output while a second window waits upstream
        rdy_mode = 0;
        @(posedge clk); #1;
        p = '{1, 1, 1, 1, 2, 3, 4, 5, 6};
        fork
            send_pkt(0, p, 0, -1);
            begin
                n = 0;
                while (!if0.m_valid && n < 100) begin @(negedge clk); n++; end
                repeat (5) begin
                    chk("stall_s_ready", if0.s_ready, 0);
                    chk("stall_m_data",  if0.m_data,  6);
                    @(negedge clk);
                end
                @(posedge clk); #1;
                rdy_mode = 1;
            end
        join
        drain();

        // Closing beat accepted in the same cycle the held result drains
        rdy_mode = 0;
        @(posedge clk); #1;
        p = '{1, 1, 1, 1, 2, 3, 9};
        fork
            send_pkt(0, p, 0, -1);
            begin
                n = 0;
                while (!if0.m_valid && n < 100) begin @(negedge clk); n++; end
                repeat (3) @(negedge clk);
                @(posedge clk); #1;
                rdy_mode = 1;
            end
        join
        chk("sameclk_valid", if0.m_valid, 1);
        chk("sameclk_data",  if0.m_data,  9);
        drain();

        p = '{-32768, -32768, -32768, -32768, -32768, -32768};
        send_pkt(0, p, 0, -1);
        p = '{-1, -1, -1, 5, 5, 5};
        send_pkt(0, p, 0, -1);
        drain();

        rdy_mode = 2;
        repeat (40) begin
            len = $urandom_range(1, 12);
            if (len == K) len++;
            p = {};
            for (int i = 0; i < len; i++) begin
                r16 = W'($urandom);
                case ($urandom_range(0, 5))
                    0:       p.push_back(-32768);
                    1:       p.push_back(32767);
                    default: p.push_back(int'($signed(r16)));
                endcase
            end
            send_pkt(0, p, 1, -1);
        end
        rdy_mode = 1;
        drain();

        p = '{3, 3, 3, 2, 2, 2};
        send_pkt(1, p, 0, 16'h7FFF);
        drain();

        // Reset in the middle of a window must drop the partial sum and the kernel
        drive_beat(1, pack(1, 1, 16'h7FFF), 1'b0);
        drive_beat(1, pack(1, 2, 16'h7FFF), 1'b0);
        drive_beat(1, pack(1, 3, 16'h7FFF), 1'b0);
        drive_beat(1, pack(1, 4, 16'h7FFF), 1'b0);
        drive_beat(1, pack(1, 5, 16'h7FFF), 1'b0);
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("midrst_m_valid", if1.m_valid, 0);
        chk("midrst_m_data",  if1.m_data,  0);
        chk("midrst_m_last",  if1.m_last,  0);
        rstn = 1'b1;
        @(posedge clk); #1;
        p = '{1, 1, 1, 1, 1, 1};
        send_pkt(1, p, 0, -1);
        drain();

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule
